// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchroniser, debouncer and edge detector whose
// presses are re-timed to the frame tick, with optional hold-to-repeat.
module input_conditioner #(
  parameter int             NCH         = 3,
  parameter int             DEB_CYCLES  = 250000,
  parameter int             DAS_TICKS   = 17,
  parameter int             ARR_TICKS   = 5,
  parameter logic [NCH-1:0] REPEAT_MASK = NCH'(3'b011)
) (
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic [NCH-1:0] btn_n,
  input  logic           tick,
  input  logic           repeat_en,
  output logic [NCH-1:0] level,
  output logic [NCH-1:0] pulse
);

  localparam int DW   = $clog2(DEB_CYCLES);
  localparam int MAXT = (DAS_TICKS > ARR_TICKS) ? DAS_TICKS : ARR_TICKS;
  localparam int RW   = $clog2(MAXT + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [RW-1:0] DAS_END  = RW'(DAS_TICKS);
  localparam logic [RW-1:0] ARR_END  = RW'(ARR_TICKS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rptState_e;

  for (genvar i = 0; i < NCH; i++) begin : gen_ch
    logic          syncA_q, syncB_q;
    logic          level_q, level_d, levelDly_q;
    logic [DW-1:0] debCnt_q, debCnt_d;
    rptState_e     state_q, state_d;
    logic [RW-1:0] rptCnt_q, rptCnt_d, rptInc;
    logic          rise, fire;
    logic          pending_q, pending_d;
    logic          pulse_q, pulse_d;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
        syncA_q    <= 1'b0;
        syncB_q    <= 1'b0;
        level_q    <= 1'b0;
        levelDly_q <= 1'b0;
        debCnt_q   <= '0;
        state_q    <= IDLE;
        rptCnt_q   <= '0;
        pending_q  <= 1'b0;
        pulse_q    <= 1'b0;
      end else begin
        syncA_q    <= ~btn_n[i];
        syncB_q    <= syncA_q;
        level_q    <= level_d;
        levelDly_q <= level_q;
        debCnt_q   <= debCnt_d;
        state_q    <= state_d;
        rptCnt_q   <= rptCnt_d;
        pending_q  <= pending_d;
        pulse_q    <= pulse_d;
      end
    end

    // The level only follows the synchronised key after it has disagreed for a full window.
    always_comb begin
      debCnt_d = '0;
      level_d  = level_q;
      if (syncB_q != level_q) begin
        if (debCnt_q == DEB_LAST) begin
          level_d = syncB_q;
        end else begin
          debCnt_d = debCnt_q + DW'(1);
        end
      end
    end

    assign rise = level_q & ~levelDly_q;

    // Release or disabling repeat wins over any counting or firing this cycle.
    always_comb begin
      state_d  = state_q;
      rptCnt_d = rptCnt_q;
      fire     = 1'b0;
      rptInc   = rptCnt_q + RW'(1);
      if (!level_q || !repeat_en) begin
        state_d  = IDLE;
        rptCnt_d = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise && REPEAT_MASK[i]) begin
              state_d  = DELAY;
              rptCnt_d = '0;
            end
          end
          DELAY: begin
            if (tick) begin
              if (rptInc == DAS_END) begin
                fire     = 1'b1;
                state_d  = REPEAT;
                rptCnt_d = '0;
              end else begin
                rptCnt_d = rptInc;
              end
            end
          end
          REPEAT: begin
            if (tick) begin
              if (rptInc == ARR_END) begin
                fire     = 1'b1;
                rptCnt_d = '0;
              end else begin
                rptCnt_d = rptInc;
              end
            end
          end
          default: begin
            state_d  = IDLE;
            rptCnt_d = '0;
          end
        endcase
      end
    end

    always_comb begin
      pulse_d   = 1'b0;
      pending_d = pending_q | rise;
      if (tick) begin
        pulse_d   = pending_q | rise | fire;
        pending_d = 1'b0;
      end
    end

    assign level[i] = level_q;
    assign pulse[i] = pulse_q;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed checks of the button front end with a short
// debounce window, DAS=3, ARR=2 and a tick every 100 cycles.
module tb_input_conditioner;

  localparam int NCH   = 3;
  localparam int FRAME = 100;
  localparam int LAT   = 18;

  logic           CLOCK_50 = 1'b0;
  logic           resetn;
  logic [NCH-1:0] btn_n;
  logic           tick;
  logic           repeat_en;
  logic [NCH-1:0] level;
  logic [NCH-1:0] pulse;

  int checks   = 0;
  int failures = 0;

  int phase   = 0;
  int k       = 0;
  int tickRel = 0;
  int strayPulses = 0;
  logic [63:0]    pulseMask [NCH];
  int             levelRises [NCH];
  int             lastRiseK [NCH];
  logic [NCH-1:0] levelSeen;
  logic [NCH-1:0] prevLevel = '0;

  typedef struct packed {
    logic [1:0]  ch;
    logic        repEn;
    logic [11:0] pressK;
    logic [11:0] holdLen;
    logic [15:0] expMask;
  } vec_t;

  vec_t vecs [8];

  input_conditioner #(
    .NCH(NCH),
    .DEB_CYCLES(16),
    .DAS_TICKS(3),
    .ARR_TICKS(2),
    .REPEAT_MASK(3'b011)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn(resetn),
    .btn_n(btn_n),
    .tick(tick),
    .repeat_en(repeat_en),
    .level(level),
    .pulse(pulse)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // One clock with the current inputs; outputs sampled on the falling edge.
  task automatic applyStimulus();
    tick = (phase == 0);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    for (int c = 0; c < NCH; c++) begin
      if (pulse[c]) begin
        if (tick && tickRel < 64) pulseMask[c][tickRel] = 1'b1;
        else strayPulses++;
      end
      if (level[c] && !prevLevel[c]) begin
        levelRises[c]++;
        lastRiseK[c] = k;
      end
      if (level[c]) levelSeen[c] = 1'b1;
    end
    prevLevel = level;
    if (tick) tickRel++;
    phase = (phase + 1) % FRAME;
    k++;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Align so that iteration k=0 carries tick T0, then clear the logs.
  task automatic startScenario();
    while (phase != 0) applyStimulus();
    k = 0;
    tickRel = 0;
    strayPulses = 0;
    levelSeen = '0;
    for (int c = 0; c < NCH; c++) begin
      pulseMask[c]  = '0;
      levelRises[c] = 0;
      lastRiseK[c]  = -1;
    end
  endtask

  task automatic runHold(input int ch, input logic repEn, input int pressK, input int holdLen);
    repeat_en = repEn;
    startScenario();
    while (k < pressK + holdLen + 300) begin
      if (k == pressK) btn_n[ch] = 1'b0;
      if (k == pressK + holdLen) btn_n[ch] = 1'b1;
      applyStimulus();
    end
    repeat_en = 1'b1;
  endtask

  task automatic resetMidHold(input int rstK, input logic [63:0] expMask);
    startScenario();
    while (k < 1300) begin
      if (k == 10) btn_n[0] = 1'b0;
      if (k == rstK) resetn = 1'b0;
      if (k == rstK + 3) resetn = 1'b1;
      if (k == 1010) btn_n[0] = 1'b1;
      applyStimulus();
      if (k == rstK + 2) begin
        checkOutput($sformatf("rst%0d_levelInReset", rstK), 64'(level), 64'h0);
        checkOutput($sformatf("rst%0d_pulseInReset", rstK), 64'(pulse), 64'h0);
      end
    end
    checkOutput($sformatf("rst%0d_mask", rstK), pulseMask[0], expMask);
    checkOutput($sformatf("rst%0d_relatch", rstK), 64'(lastRiseK[0] - (rstK + 3) + 1), 64'(LAT));
    checkOutput($sformatf("rst%0d_rises", rstK), 64'(levelRises[0]), 64'd2);
    checkOutput($sformatf("rst%0d_stray", rstK), 64'(strayPulses), 64'd0);
  endtask

  initial begin
    // ch, repeat_en, press cycle after T0, hold cycles, expected pulse ticks
    vecs[0] = '{2'd1, 1'b1, 12'd10, 12'd40,   16'h0002};
    vecs[1] = '{2'd0, 1'b1, 12'd10, 12'd1000, 16'h02AA};
    vecs[2] = '{2'd1, 1'b1, 12'd10, 12'd1000, 16'h02AA};
    vecs[3] = '{2'd2, 1'b1, 12'd10, 12'd1000, 16'h0002};
    vecs[4] = '{2'd0, 1'b0, 12'd10, 12'd1000, 16'h0002};
    vecs[5] = '{2'd0, 1'b1, 12'd82, 12'd1000, 16'h0552};
    vecs[6] = '{2'd0, 1'b1, 12'd10, 12'd273,  16'h000A};
    vecs[7] = '{2'd0, 1'b1, 12'd10, 12'd272,  16'h0002};

    resetn    = 1'b0;
    btn_n     = '1;
    tick      = 1'b0;
    repeat_en = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("resetLevel", 64'(level), 64'h0);
    checkOutput("resetPulse", 64'(pulse), 64'h0);
    resetn = 1'b1;
    repeat (5) applyStimulus();

    startScenario();
    while (k < 800) begin
      if (k < 500) btn_n[0] = ((k / 10) % 2 == 0) ? 1'b0 : 1'b1;
      else btn_n[0] = 1'b1;
      applyStimulus();
    end
    checkOutput("bounceLevel", 64'(levelSeen[0]), 64'h0);
    checkOutput("bouncePulse", pulseMask[0], 64'h0);
    checkOutput("bounceStray", 64'(strayPulses), 64'd0);

    startScenario();
    while (k < 300) begin
      if (k == 1 || k == 50) btn_n[0] = 1'b0;
      if (k == 31 || k == 80) btn_n[0] = 1'b1;
      applyStimulus();
    end
    checkOutput("collapseMask", pulseMask[0], 64'h2);
    checkOutput("collapseRises", 64'(levelRises[0]), 64'd2);
    checkOutput("collapseStray", 64'(strayPulses), 64'd0);

    for (int i = 0; i < 8; i++) begin
      runHold(int'(vecs[i].ch), vecs[i].repEn, int'(vecs[i].pressK), int'(vecs[i].holdLen));
      for (int c = 0; c < NCH; c++) begin
        checkOutput($sformatf("vec%0d_ch%0d_mask", i, c), pulseMask[c],
                    (c == int'(vecs[i].ch)) ? 64'(vecs[i].expMask) : 64'h0);
      end
      checkOutput($sformatf("vec%0d_latency", i),
                  64'(lastRiseK[vecs[i].ch] - int'(vecs[i].pressK) + 1), 64'(LAT));
      checkOutput($sformatf("vec%0d_rises", i), 64'(levelRises[vecs[i].ch]), 64'd1);
      checkOutput($sformatf("vec%0d_stray", i), 64'(strayPulses), 64'd0);
    end

    startScenario();
    while (k < 1300) begin
      if (k == 10) btn_n[0] = 1'b0;
      if (k == 400) repeat_en = 1'b0;
      if (k == 1010) btn_n[0] = 1'b1;
      applyStimulus();
    end
    repeat_en = 1'b1;
    checkOutput("enDropMask", pulseMask[0], 64'hA);
    checkOutput("enDropStray", 64'(strayPulses), 64'd0);

    resetMidHold(400, 64'h2AA);
    resetMidHold(300, 64'h552);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Parametrised, multi-channel button front end feeding the game FSM with clean action pulses. Each channel takes one raw active-low key and runs synchronise, debounce and rising-edge detect. It then re-times actions to the input frame tick, so a channel issues at most one action per frame. It adds per-channel hold-to-repeat (delayed auto-shift), so a held left/right key keeps moving the piece while rotate stays one-shot.

## Interface
Parameters:
- NCH, 3, number of channels (bit i = channel i)
- DEB_CYCLES, 250000, clock cycles a synchronised input must hold a new value before the debounced level follows (5 ms at 50 MHz); legal range ≥2
- DAS_TICKS, 17, ticks from press to first repeat; legal range ≥1
- ARR_TICKS, 5, ticks between subsequent repeats; legal range ≥1
- REPEAT_MASK, NCH'b011, channels allowed to auto-repeat

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- btn_n  in  NCH  raw keys, active low, asynchronous to CLOCK_50
- tick  in  1  one-cycle input frame strobe (100 Hz)
- repeat_en  in  1  global auto-repeat enable
- level  out  NCH  debounced key state, 1 = pressed
- pulse  out  NCH  registered action strobe, one cycle wide

## Operation
Each channel is independent and identical.
- Sync: ~btn_n[i] passes through two flops, each reset to 0.
- Debounce: a counter of width $clog2(DEB_CYCLES) increments while sync ≠ level and clears to 0 while sync = level. When it reaches DEB_CYCLES−1 with sync still ≠ level:
  - level <= sync
  - counter <= 0
  - Any sync glitch shorter than DEB_CYCLES cycles never changes level.
- Edge: rise = level & ~level_d. level_d is a flop of level, reset 0.
- Repeat FSM, 2-bit, states IDLE / DELAY / REPEAT. The repeat counter is wide enough for max(DAS_TICKS, ARR_TICKS).
  - IDLE → DELAY on rise, only if REPEAT_MASK[i] & repeat_en. cnt <= 0.
  - DELAY: each tick with level=1 does cnt++. When cnt reaches DAS_TICKS, the FSM asserts fire, goes to REPEAT and sets cnt <= 0.
  - REPEAT: each tick does cnt++. When cnt reaches ARR_TICKS, the FSM asserts fire and sets cnt <= 0.
  - Any state → IDLE when level=0 or repeat_en=0. This check has priority over counting and fire.
  - A rise coinciding with tick enters DELAY; that tick is not counted.
  - fire is only ever asserted on a tick cycle.
- Pending/re-time:
  - Non-tick cycle: pending <= pending | rise.
  - Tick cycle: pulse <= pending | rise | fire, and pending <= 0.
  - Any number of rises between two ticks collapse to one pulse.
  - A press and release that both complete between ticks still yields one pulse.

## Timing
- Reset values: level=0, pulse=0, sync flops=0, counters=0, pending=0, FSM=IDLE. Reset takes effect immediately and asynchronously.
- Reset mid-operation: all state is lost. A key still held at reset release re-debounces and is treated as a fresh press, producing one pulse and restarting DAS.
- btn_n steady low → level high after 2 + DEB_CYCLES cycles. Release has the same latency.
- Press pulse appears in the cycle after the first tick following the rise. If rise and tick coincide, pulse appears the next cycle.
- Between consecutive ticks, pulse[i] is high for at most one cycle. pulse is never high on two consecutive cycles.
- Hold pulse sequence: with rise between T0 and T1, pulses follow T1, T(DAS_TICKS), then every ARR_TICKS ticks.
  - If DAS_TICKS=1, T1 carries both press and fire; this yields a single pulse.
- Release: the last possible pulse is at the tick where level is still 1. No pulse after level falls, except an already pending press.
- All output widths equal NCH. Counters saturate only by wrap-to-0 on match; no other arithmetic.

## Test plan
Bench parameters: NCH=3, DEB_CYCLES=16, DAS_TICKS=3, ARR_TICKS=2, REPEAT_MASK=3'b011, tick every 100 cycles.
- Bounce rejection: btn_n[0] toggles every 10 cycles for 500 cycles, then returns high → level[0] stays 0, pulse stays 0.
- Clean tap: btn_n[1] low 40 cycles mid-frame → level[1] rises 18 cycles after the fall; exactly one pulse[1], in the cycle after the next tick.
- Collapse: two separate 30-cycle taps on channel 0 within one frame → exactly one pulse[0] after the next tick.
- Auto-repeat: channel 0 held for 10 frames, press before T1 → pulses after T1, T3, T5, T7, T9; none after release.
- No repeat: channel 2 held (mask 0), and separately channel 0 held with repeat_en=0 → one pulse each. Dropping repeat_en at T4 mid-repeat stops further pulses.
- Reset mid-hold: resetn low 3 cycles at T4 with channel 0 held → level/pulse read 0 during reset. After release: level rises after 18 cycles, then a fresh press pulse and repeat restarts DAS.
